// File: rtl/fmap_rdout_pkg.sv
// Shared sizing for the feature-map buffer readback path and the credit helper
// used between the read issue logic and the output FIFO.
package fmap_rdout_pkg;

    localparam int FMAP_DATA_SIZE = 16;
    localparam int FMAP_MEM_SIZE  = 16;

    localparam int RD_FIFO_DEPTH = 4;
    localparam int RD_FIFO_AW    = 2;
    localparam int RD_FIFO_CW    = 3;

    // A new read may issue only if every word already owed to the FIFO still leaves a slot.
    function automatic logic rd_credit_ok(input logic [RD_FIFO_CW-1:0] occ,
                                          input logic                  inflight);
        return (int'(occ) + int'(inflight)) < RD_FIFO_DEPTH;
    endfunction

endpackage

// File: rtl/fmap_rdout_if.sv
// Buffer read port plus valid/ready output stream of the feature-map reader.
// master = the reader itself, slave = buffer + downstream consumer.
interface fmap_rdout_if #(
    parameter int DATA_SIZE = 16,
    parameter int MEM_SIZE  = 16
);
    logic                 in_re;
    logic [MEM_SIZE-1:0]  in_ra;
    logic [DATA_SIZE-1:0] in_rd;
    logic                 out_valid;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_last;
    logic                 out_ready;

    modport master (
        output in_re, in_ra, out_valid, out_data, out_last,
        input  in_rd, out_ready
    );

    modport slave (
        input  in_re, in_ra, out_valid, out_data, out_last,
        output in_rd, out_ready
    );
endinterface

// File: rtl/fmap_rdout_rd_fifo.sv
// Four-entry FIFO holding {last, data} for words returned by the buffer.
// A push while full is accepted when the same cycle pops.
module fmap_rdout_rd_fifo
    import fmap_rdout_pkg::*;
#(
    parameter int W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [W-1:0]          din_i,
    input  logic                  pop_i,
    output logic [W-1:0]          dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [RD_FIFO_CW-1:0] count_o
);

    logic [W-1:0]          mem_q [RD_FIFO_DEPTH];
    logic [RD_FIFO_AW-1:0] wr_ptr_q;
    logic [RD_FIFO_AW-1:0] rd_ptr_q;
    logic [RD_FIFO_CW-1:0] count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == RD_FIFO_CW'(RD_FIFO_DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fmap_rdout.sv
// Streams feature-map buffer words 0..M*nIR*nIC-1 out in address order,
// hiding the 1-cycle read latency and downstream backpressure behind a 4-deep FIFO.
module fmap_rdout
    import fmap_rdout_pkg::*;
#(
    parameter int DATA_SIZE = FMAP_DATA_SIZE,
    parameter int MEM_SIZE  = FMAP_MEM_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] M,
    input  logic [DATA_SIZE-1:0] nIR,
    input  logic [DATA_SIZE-1:0] nIC,
    output logic                 done,
    fmap_rdout_if.master         bus
);

    // state    | meaning
    // ST_IDLE  | done=1, waiting for en with a non-zero extent
    // ST_READ  | issuing reads 0..N-1 as FIFO credit allows
    // ST_DRAIN | all reads issued, waiting for last word to leave the FIFO
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int NW = 3 * DATA_SIZE;

    state_t                state_q;
    logic [MEM_SIZE-1:0]   addr_q;
    logic [NW-1:0]         n_q;
    logic [NW-1:0]         n_d;
    logic                  done_q;
    logic                  inflight_q;
    logic                  last_inflight_q;

    logic                  issue;
    logic                  is_last_rd;
    logic                  drain_done;

    logic [DATA_SIZE:0]    fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [RD_FIFO_CW-1:0] fifo_count;
    logic                  fifo_pop;

    assign n_d = NW'(M) * NW'(nIR) * NW'(nIC);

    assign is_last_rd = (NW'(addr_q) == (n_q - NW'(1)));
    assign issue      = (state_q == ST_READ) && !fifo_full
                        && rd_credit_ok(fifo_count, inflight_q);
    assign fifo_pop   = !fifo_empty && bus.out_ready;

    // Finish in the same cycle the final word is handed off so done is not a cycle late.
    assign drain_done = !inflight_q
                        && (fifo_empty || ((fifo_count == RD_FIFO_CW'(1)) && fifo_pop));

    fmap_rdout_rd_fifo #(
        .W(DATA_SIZE + 1)
    ) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   ({last_inflight_q, bus.in_rd}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            n_q             <= '0;
            done_q          <= 1'b1;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            last_inflight_q <= issue && is_last_rd;
            case (state_q)
                ST_IDLE: begin
                    if (en && (n_d != '0)) begin
                        n_q     <= n_d;
                        addr_q  <= '0;
                        done_q  <= 1'b0;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr_q <= addr_q + 1'b1;
                        if (is_last_rd) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        addr_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done          = done_q;
    assign bus.in_re     = issue;
    assign bus.in_ra     = addr_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_dout[DATA_SIZE-1:0];
    // Stale FIFO slots may still carry a last flag; only a live head may assert it.
    assign bus.out_last  = !fifo_empty && fifo_dout[DATA_SIZE];

endmodule

// File: tb/tb_fmap_rdout.sv
// Directed bench for fmap_rdout: buffer model returns addr+1, stream and timing checked.
module tb_fmap_rdout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] M   = '0;
    logic [15:0] nIR = '0;
    logic [15:0] nIC = '0;
    logic        done;

    fmap_rdout_if #(.DATA_SIZE(16), .MEM_SIZE(16)) bus ();

    fmap_rdout #(.DATA_SIZE(16), .MEM_SIZE(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .M    (M),
        .nIR  (nIR),
        .nIC  (nIC),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int t0       = 0;

    int   got_q[$];
    int   last_q[$];
    int   cyc_q[$];
    int   outstanding;
    int   max_out;
    int   n_reads;
    int   done_cyc;
    int   done_at1;
    bit   run_on;
    bit   saw_re;
    bit   saw_valid;
    bit   saw_done_low;

    logic [23:0] rdy_pat = 24'b1011_0001_1101_0110_1100_0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer read port: 1-cycle latency, contents addr+1.
    initial bus.in_rd = '0;
    always @(posedge clk) begin
        if (bus.in_re) bus.in_rd <= bus.in_ra + 16'd1;
    end

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
        end else if (run_on) begin
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(int'(bus.out_data));
                last_q.push_back(int'(bus.out_last));
                cyc_q.push_back(cyc - t0);
                outstanding--;
            end
            if (bus.in_re) begin
                outstanding++;
                n_reads++;
                saw_re = 1'b1;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (bus.out_valid) saw_valid = 1'b1;
            if (!done) saw_done_low = 1'b1;
            if (cyc - t0 == 1) done_at1 = int'(done);
            if (done && done_cyc < 0 && (cyc - t0) >= 1) done_cyc = cyc - t0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        run_on       = 1'b0;
        got_q.delete();
        last_q.delete();
        cyc_q.delete();
        outstanding  = 0;
        max_out      = 0;
        n_reads      = 0;
        done_cyc     = -1;
        done_at1     = -1;
        saw_re       = 1'b0;
        saw_valid    = 1'b0;
        saw_done_low = 1'b0;
    endtask

    task automatic start_run(input int m, input int r, input int c);
        @(posedge clk);
        #1;
        t0     = cyc;
        run_on = 1'b1;
        en     = 1'b1;
        M      = 16'(m);
        nIR    = 16'(r);
        nIC    = 16'(c);
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int nwords, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(done && got_q.size() >= nwords) && k < budget);
        if (k >= budget) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Stream contents 1..n, last only on n; optional exact cycles and done cycle.
    task automatic check_stream(input string tag, input int n, input bit timed);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(got_q[i]), 32'(i + 1));
            chk($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == n - 1));
            if (timed) chk($sformatf("%s_cyc%0d", tag, i), 32'(cyc_q[i]), 32'(3 + i));
        end
        if (timed) chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(3 + n));
        chk({tag, "_done_at1"}, 32'(done_at1), 32'd0);
        chk({tag, "_reads"}, 32'(n_reads), 32'(n));
    endtask

    initial begin
        bus.out_ready = 1'b1;
        clear_mon();

        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd1);
        chk("rst_in_re", 32'(bus.in_re), 32'd0);
        chk("rst_in_ra", 32'(bus.in_ra), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 2x2x2, ready high: words on cycles 3..10, done at 11.
        clear_mon();
        start_run(2, 2, 2);
        wait_idle("full", 8, 40);
        check_stream("full", 8, 1'b1);
        chk("full_max_out", 32'(max_out), 32'd2);

        // Same extent under backpressure; the long initial stall fills all four credits.
        clear_mon();
        bus.out_ready = 1'b0;
        start_run(2, 2, 2);
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    @(posedge clk);
                    #1 bus.out_ready = rdy_pat[k];
                end
                bus.out_ready = 1'b1;
            end
            wait_idle("bp", 8, 80);
        join
        check_stream("bp", 8, 1'b0);
        chk("bp_max_out", 32'(max_out), 32'd4);

        // Zero extent: nothing happens.
        clear_mon();
        start_run(0, 5, 7);
        repeat (10) @(negedge clk);
        chk("zero_re", 32'(saw_re), 32'd0);
        chk("zero_valid", 32'(saw_valid), 32'd0);
        chk("zero_done_low", 32'(saw_done_low), 32'd0);

        // Single word.
        clear_mon();
        start_run(1, 1, 1);
        wait_idle("one", 1, 20);
        check_stream("one", 1, 1'b1);

        // en pulsed mid-run with a different extent is ignored.
        clear_mon();
        start_run(2, 4, 1);
        repeat (2) @(posedge clk);
        #1;
        en = 1'b1; M = 16'd1; nIR = 16'd1; nIC = 16'd1;
        @(posedge clk);
        #1 en = 1'b0;
        wait_idle("midEn", 8, 40);
        check_stream("midEn", 8, 1'b1);

        // Reset after the third word, then restart with a 4-word extent.
        clear_mon();
        start_run(2, 2, 2);
        begin
            int k;
            k = 0;
            do begin
                @(negedge clk);
                #1;
                k++;
            end while (got_q.size() < 3 && k < 20);
            if (k >= 20) chk("abort_wait_timeout", 32'd0, 32'd1);
        end
        rst = 1'b1;
        #1;
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_in_re", 32'(bus.in_re), 32'd0);
        chk("abort_in_ra", 32'(bus.in_ra), 32'd0);
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_data", 32'(bus.out_data), 32'd0);
        chk("abort_last", 32'(bus.out_last), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        start_run(1, 2, 2);
        wait_idle("restart", 4, 30);
        check_stream("restart", 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fmap_rdout.md
# fmap_rdout

Streaming reader for the on-chip feature-map buffer. On `en` it reads words `0 .. M*nIR*nIC-1` from the buffer read port and delivers them in address order on a valid/ready output stream, absorbing the memory's 1-cycle read latency and downstream backpressure in a small FIFO. It is the readback counterpart of the buffer erase/fill writers: it uses the same `en`/`done` command handshake and the same `M`, `nIR`, `nIC` extent inputs, and sits between the buffer and the result/host output path.

## Interface
- `DATA_SIZE`, default 16: word width and width of each extent input.
- `MEM_SIZE`, default 16: buffer address width.
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `en` in 1: start pulse; sampled only in IDLE.
- `M`, `nIR`, `nIC` in DATA_SIZE each: extents, sampled on the accepted `en`.
- `done` out 1: 1 = idle/complete.
- `in_re` out 1: buffer read enable.
- `in_ra` out MEM_SIZE: buffer read address.
- `in_rd` in DATA_SIZE: buffer read data, valid exactly 1 cycle after the `in_re` cycle.
- `out_valid` out 1: output word available.
- `out_data` out DATA_SIZE: output word.
- `out_last` out 1: qualifies the final word of the run.
- `out_ready` in 1: downstream accept.

## Operation
- Reset values: `done`=1, `in_re`=0, `in_ra`=0, `out_valid`=0, `out_data`=0, `out_last`=0; FIFO emptied; state IDLE.
- N = M*nIR*nIC, computed at full width (3*DATA_SIZE) and latched on the accepted `en`. Address compares use the zero-extended address.
- States:
  - IDLE: if `en` and N≠0, go to READ with `done`=0 and the read address at 0. If `en` and N=0, no reads are issued and `done` stays 1.
  - READ: issue reads at addresses 0..N-1, incrementing `in_ra` by 1 per issued read. After the read of N-1 is issued, go to DRAIN.
  - DRAIN: wait until every outstanding read has landed and the FIFO has emptied through handshakes, then go to IDLE with `done`=1 and `in_ra`=0.
- Credit rule: FIFO depth is 4. FIFO occupancy plus reads in flight never exceeds 4. `in_re` is deasserted for any cycle in which issuing would break this rule.
- Every `in_rd` word returned for an issued read is pushed into the FIFO; none is ever dropped.
- Output side: `out_valid` = FIFO not empty, and `out_data` = FIFO head. A word transfers on `out_valid & out_ready`.
- `out_last` is 1 only together with the word from address N-1.
- `en` is ignored outside IDLE.
- Reset mid-run aborts immediately. In-flight read data is discarded, and the next `en` restarts from address 0.

## Timing
- `en` accepted at cycle 0 -> `in_re`=1 with `in_ra`=0 in cycle 1 -> `in_rd` valid in cycle 2 -> `out_valid`=1 with word 0 in cycle 3. Latency is 3 cycles.
- With `out_ready` held high: one read per cycle and one output word per cycle, with no bubbles.
- The last word transfers at cycle 2+N. `done` rises at cycle 3+N.
- `done` falls in the cycle after `en` is accepted.
- A simultaneous FIFO push and pop at full occupancy is legal. Occupancy is unchanged.

## Structure
- `DATA_SIZE` and `MEM_SIZE` come from the shared parameter include used by all buffer-access blocks. State encodings stay local.
- One sub-module, `rd_fifo`: 4-entry synchronous FIFO with push/pop, empty/full flags and count, and the same asynchronous reset. It stores `{last, data}`.
- The top level holds the FSM, the address counter and the in-flight/credit logic.

## Test plan
- M=2, nIR=2, nIC=2; buffer preloaded with addr+1; `out_ready`=1 -> `out_data` is 1..8 on cycles 3..10, `out_last` only with value 8, `done`=1 from cycle 11.
- Same run with `out_ready` toggled by a pseudo-random pattern -> words arrive exactly 1..8 with none lost or duplicated. Occupancy plus in-flight reads never exceeds 4; `in_re` is low while the FIFO is full.
- M=0 (any nIR, nIC) -> `in_re` never asserts, `done` stays 1, `out_valid` stays 0.
- M=nIR=nIC=1 -> exactly one word, value 1, with `out_last`=1; `done` back to 1 at cycle 4.
- `en` pulsed again mid-run -> ignored; the stream is unchanged.
- `rst` asserted after the third word, then `en` with a 4-word extent -> all outputs return to reset values immediately. The new stream restarts at address 0 and returns 1..4.
